// File: rtl/bsg_clk_mon_multi_if.sv
// rtl/bsg_clk_mon_multi_if.sv - control, monitor and result bundle for bsg_clk_mon_multi
interface bsg_clk_mon_multi_if #(
  parameter int num_chan_p  = 4,
  parameter int cnt_width_p = 16,
  parameter int win_width_p = 20
);
  logic [num_chan_p-1:0]             mon_i;
  logic [num_chan_p-1:0]             chan_en_i;
  logic                              start_i;
  logic                              stop_i;
  logic                              mode_i;
  logic [win_width_p-1:0]            win_len_i;
  logic [cnt_width_p-1:0]            lo_thresh_i;
  logic [cnt_width_p-1:0]            hi_thresh_i;
  logic                              busy_o;
  logic                              done_o;
  logic [num_chan_p*cnt_width_p-1:0] count_o;
  logic [num_chan_p-1:0]             sat_o;
  logic [num_chan_p-1:0]             low_o;
  logic [num_chan_p-1:0]             high_o;

  modport master (
    output mon_i, chan_en_i, start_i, stop_i, mode_i, win_len_i, lo_thresh_i, hi_thresh_i,
    input  busy_o, done_o, count_o, sat_o, low_o, high_o
  );

  modport slave (
    input  mon_i, chan_en_i, start_i, stop_i, mode_i, win_len_i, lo_thresh_i, hi_thresh_i,
    output busy_o, done_o, count_o, sat_o, low_o, high_o
  );
endinterface

// File: rtl/bsg_clk_mon_multi.sv
// rtl/bsg_clk_mon_multi.sv - multi-channel clock frequency monitor
module bsg_clk_mon_multi #(
  parameter int num_chan_p  = 4,
  parameter int cnt_width_p = 16,
  parameter int win_width_p = 20
) (
  input logic                clk_i,
  input logic                reset_n_i,
  bsg_clk_mon_multi_if.slave mon_if
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2,
    S_LATCH   = 2'd3
  } state_e;

  state_e                                   state_q, state_d;
  logic [num_chan_p-1:0]                    prev_q, prev_d;
  logic [num_chan_p-1:0]                    en_q, en_d;
  logic                                     mode_q, mode_d;
  logic [win_width_p-1:0]                   win_cnt_q, win_cnt_d;
  logic [num_chan_p-1:0][cnt_width_p-1:0]   cnt_q, cnt_d;
  logic [num_chan_p-1:0]                    sat_acc_q, sat_acc_d;
  logic [num_chan_p*cnt_width_p-1:0]        count_q, count_d;
  logic [num_chan_p-1:0]                    sat_q, sat_d;
  logic [num_chan_p-1:0]                    low_q, low_d;
  logic [num_chan_p-1:0]                    high_q, high_d;
  logic                                     done_q, done_d;
  logic [num_chan_p-1:0]                    edge_w;

  assign edge_w = mon_if.mon_i & ~prev_q;

  assign mon_if.busy_o  = (state_q != S_IDLE);
  assign mon_if.done_o  = done_q;
  assign mon_if.count_o = count_q;
  assign mon_if.sat_o   = sat_q;
  assign mon_if.low_o   = low_q;
  assign mon_if.high_o  = high_q;

  // Next-state, window counting and result latching
  always_comb begin
    state_d   = state_q;
    prev_d    = mon_if.mon_i;
    en_d      = en_q;
    mode_d    = mode_q;
    win_cnt_d = win_cnt_q;
    cnt_d     = cnt_q;
    sat_acc_d = sat_acc_q;
    count_d   = count_q;
    sat_d     = sat_q;
    low_d     = low_q;
    high_d    = high_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mon_if.start_i && !mon_if.stop_i && (mon_if.win_len_i != '0)) begin
          state_d = S_ARM;
        end
      end

      S_ARM: begin
        en_d      = mon_if.chan_en_i;
        mode_d    = mon_if.mode_i;
        win_cnt_d = mon_if.win_len_i;
        cnt_d     = '0;
        sat_acc_d = '0;
        state_d   = S_MEASURE;
      end

      S_MEASURE: begin
        if (mon_if.stop_i) begin
          state_d = S_IDLE;
        end else begin
          for (int i = 0; i < num_chan_p; i++) begin
            if (en_q[i] && edge_w[i]) begin
              // An edge that would wrap the counter is dropped and flagged instead
              if (cnt_q[i] == '1) begin
                sat_acc_d[i] = 1'b1;
              end else begin
                cnt_d[i] = cnt_q[i] + cnt_width_p'(1);
              end
            end
          end
          win_cnt_d = win_cnt_q - win_width_p'(1);
          if (win_cnt_q == win_width_p'(1)) begin
            state_d = S_LATCH;
          end
        end
      end

      S_LATCH: begin
        for (int i = 0; i < num_chan_p; i++) begin
          count_d[i*cnt_width_p +: cnt_width_p] = en_q[i] ? cnt_q[i] : '0;
          sat_d[i]  = en_q[i] & sat_acc_q[i];
          low_d[i]  = en_q[i] & (cnt_q[i] < mon_if.lo_thresh_i);
          high_d[i] = en_q[i] & (cnt_q[i] > mon_if.hi_thresh_i);
        end
        done_d = 1'b1;
        // A zero window cannot be re-armed, so continuous mode falls back to idle
        if (mode_q && !mon_if.stop_i && (mon_if.win_len_i != '0)) begin
          state_d = S_ARM;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low clear
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      prev_q    <= '0;
      en_q      <= '0;
      mode_q    <= 1'b0;
      win_cnt_q <= '0;
      cnt_q     <= '0;
      sat_acc_q <= '0;
      count_q   <= '0;
      sat_q     <= '0;
      low_q     <= '0;
      high_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      win_cnt_q <= win_cnt_d;
      cnt_q     <= cnt_d;
      sat_acc_q <= sat_acc_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
      low_q     <= low_d;
      high_q    <= high_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_bsg_clk_mon_multi.sv
// tb/tb_bsg_clk_mon_multi.sv - directed self-checking bench for bsg_clk_mon_multi
module tb_bsg_clk_mon_multi;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  bsg_clk_mon_multi_if #(.num_chan_p(4), .cnt_width_p(16), .win_width_p(20)) a_if ();
  bsg_clk_mon_multi_if #(.num_chan_p(4), .cnt_width_p(8),  .win_width_p(20)) b_if ();

  bsg_clk_mon_multi #(.num_chan_p(4), .cnt_width_p(16), .win_width_p(20)) dut_a (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .mon_if    (a_if.slave)
  );

  bsg_clk_mon_multi #(.num_chan_p(4), .cnt_width_p(8), .win_width_p(20)) dut_b (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .mon_if    (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a_if.mon_i = '0; a_if.chan_en_i = '0; a_if.start_i = 0; a_if.stop_i = 0; a_if.mode_i = 0;
    a_if.win_len_i = '0; a_if.lo_thresh_i = '0; a_if.hi_thresh_i = '1;
    b_if.mon_i = '0; b_if.chan_en_i = '0; b_if.start_i = 0; b_if.stop_i = 0; b_if.mode_i = 0;
    b_if.win_len_i = '0; b_if.lo_thresh_i = '0; b_if.hi_thresh_i = '1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    tick(); tick();
    n_cmp++; if (a_if.busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", a_if.busy_o); end
    n_cmp++; if (a_if.done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", a_if.done_o); end
    n_cmp++; if (a_if.count_o !== 64'h0) begin n_err++; $display("FAIL reset_count: got %h want 0", a_if.count_o); end
    n_cmp++; if ({a_if.sat_o, a_if.low_o, a_if.high_o} !== 12'h0) begin n_err++; $display("FAIL reset_flags: got %h want 0", {a_if.sat_o, a_if.low_o, a_if.high_o}); end
    reset_n = 1;
    tick();
  endtask

  task automatic test_one_shot();
    int n_done = 0;
    a_if.chan_en_i = 4'b0001; a_if.mode_i = 0; a_if.win_len_i = 20'd100;
    a_if.lo_thresh_i = '0; a_if.hi_thresh_i = '1;
    for (int c = 0; c <= 110; c++) begin
      n_cmp++; if (a_if.done_o !== (c == 103)) begin n_err++; $display("FAIL oneshot_done_c%0d: got %b want %b", c, a_if.done_o, (c == 103)); end
      if (a_if.done_o) n_done++;
      if (c == 102) begin
        n_cmp++; if (a_if.busy_o !== 1'b1) begin n_err++; $display("FAIL oneshot_busy_latch: got %b want 1", a_if.busy_o); end
      end
      if (c == 103) begin
        n_cmp++; if (a_if.busy_o !== 1'b0) begin n_err++; $display("FAIL oneshot_busy_done: got %b want 0", a_if.busy_o); end
        n_cmp++; if (a_if.count_o[15:0] !== 16'd25) begin n_err++; $display("FAIL oneshot_ch0: got %0d want 25", a_if.count_o[15:0]); end
        n_cmp++; if (a_if.count_o[63:16] !== 48'h0) begin n_err++; $display("FAIL oneshot_others: got %h want 0", a_if.count_o[63:16]); end
      end
      a_if.start_i = (c == 0);
      a_if.mon_i = '0;
      a_if.mon_i[0] = (((c + 2) % 4) >= 2);
      a_if.mon_i[1] = c[0];
      tick();
    end
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL oneshot_ndone: got %0d want 1", n_done); end
    idle_inputs();
  endtask

  task automatic test_thresholds();
    int n_exp[4] = '{25, 10, 40, 30};
    int j;
    a_if.chan_en_i = 4'b0111; a_if.mode_i = 0; a_if.win_len_i = 20'd100;
    a_if.lo_thresh_i = 16'd20; a_if.hi_thresh_i = 16'd30;
    for (int c = 0; c <= 105; c++) begin
      if (c == 103) begin
        n_cmp++; if (a_if.done_o !== 1'b1) begin n_err++; $display("FAIL thr_done: got %b want 1", a_if.done_o); end
        n_cmp++; if (a_if.count_o !== {16'd0, 16'd40, 16'd10, 16'd25}) begin n_err++; $display("FAIL thr_counts: got %h want %h", a_if.count_o, {16'd0, 16'd40, 16'd10, 16'd25}); end
        n_cmp++; if (a_if.low_o !== 4'b0010) begin n_err++; $display("FAIL thr_low: got %b want 0010", a_if.low_o); end
        n_cmp++; if (a_if.high_o !== 4'b0100) begin n_err++; $display("FAIL thr_high: got %b want 0100", a_if.high_o); end
        n_cmp++; if (a_if.sat_o !== 4'b0000) begin n_err++; $display("FAIL thr_sat: got %b want 0000", a_if.sat_o); end
      end
      a_if.start_i = (c == 0);
      j = c - 2;
      for (int ch = 0; ch < 4; ch++) begin
        a_if.mon_i[ch] = (j >= 0) && (j % 2 == 1) && (j < 2 * n_exp[ch]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_continuous_stop();
    int n_done = 0;
    a_if.chan_en_i = 4'b0100; a_if.mode_i = 1; a_if.win_len_i = 20'd10;
    for (int c = 0; c <= 70; c++) begin
      n_cmp++; if (a_if.done_o !== (c == 13 || c == 25 || c == 37)) begin n_err++; $display("FAIL cont_done_c%0d: got %b want %b", c, a_if.done_o, (c == 13 || c == 25 || c == 37)); end
      if (a_if.done_o) begin
        n_done++;
        n_cmp++; if (a_if.count_o[47:32] !== 16'd5) begin n_err++; $display("FAIL cont_count_c%0d: got %0d want 5", c, a_if.count_o[47:32]); end
      end
      if (c == 40) begin
        n_cmp++; if (a_if.busy_o !== 1'b1) begin n_err++; $display("FAIL cont_busy_pre_stop: got %b want 1", a_if.busy_o); end
      end
      if (c == 41) begin
        n_cmp++; if (a_if.busy_o !== 1'b0) begin n_err++; $display("FAIL cont_busy_post_stop: got %b want 0", a_if.busy_o); end
      end
      a_if.start_i = (c == 0);
      a_if.stop_i  = (c == 40);
      a_if.mon_i   = '0;
      a_if.mon_i[2] = c[0];
      tick();
    end
    n_cmp++; if (n_done !== 3) begin n_err++; $display("FAIL cont_ndone: got %0d want 3", n_done); end
    n_cmp++; if (a_if.count_o[47:32] !== 16'd5) begin n_err++; $display("FAIL cont_hold: got %0d want 5", a_if.count_o[47:32]); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int n_done = 0;
    a_if.chan_en_i = 4'b1111; a_if.mode_i = 0; a_if.win_len_i = 20'd100;
    for (int c = 0; c < 52; c++) begin
      a_if.start_i = (c == 0);
      a_if.mon_i = {4{c[0]}};
      reset_n = !(c == 50 || c == 51);
      tick();
    end
    reset_n = 1;
    n_cmp++; if (a_if.busy_o !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", a_if.busy_o); end
    n_cmp++; if (a_if.done_o !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b want 0", a_if.done_o); end
    n_cmp++; if (a_if.count_o !== 64'h0) begin n_err++; $display("FAIL rstmid_count: got %h want 0", a_if.count_o); end
    n_cmp++; if ({a_if.sat_o, a_if.low_o, a_if.high_o} !== 12'h0) begin n_err++; $display("FAIL rstmid_flags: got %h want 0", {a_if.sat_o, a_if.low_o, a_if.high_o}); end
    for (int c = 0; c < 200; c++) begin
      a_if.mon_i = {4{c[0]}};
      if (a_if.done_o) n_done++;
      tick();
    end
    n_cmp++; if (n_done !== 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d want 0", n_done); end
    idle_inputs();
  endtask

  task automatic test_ignored();
    int n_busy;
    int n_done;
    n_busy = 0;
    a_if.win_len_i = 20'd0; a_if.chan_en_i = 4'b0001;
    a_if.start_i = 1; tick(); a_if.start_i = 0;
    for (int c = 0; c < 5; c++) begin if (a_if.busy_o) n_busy++; tick(); end
    n_cmp++; if (n_busy !== 0) begin n_err++; $display("FAIL ign_zero_win: busy cycles %0d want 0", n_busy); end
    n_busy = 0;
    a_if.win_len_i = 20'd5;
    a_if.start_i = 1; a_if.stop_i = 1; tick(); a_if.start_i = 0; a_if.stop_i = 0;
    for (int c = 0; c < 5; c++) begin if (a_if.busy_o) n_busy++; tick(); end
    n_cmp++; if (n_busy !== 0) begin n_err++; $display("FAIL ign_start_stop: busy cycles %0d want 0", n_busy); end
    n_done = 0;
    a_if.win_len_i = 20'd20;
    for (int c = 0; c <= 60; c++) begin
      if (a_if.done_o) begin
        n_done++;
        n_cmp++; if (c !== 23) begin n_err++; $display("FAIL ign_busy_start_cycle: done at %0d want 23", c); end
      end
      a_if.start_i = (c == 0 || c == 10);
      tick();
    end
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL ign_busy_start_ndone: got %0d want 1", n_done); end
    idle_inputs();
  endtask

  task automatic test_saturation();
    b_if.chan_en_i = 4'b0011; b_if.mode_i = 0; b_if.win_len_i = 20'd1000;
    b_if.lo_thresh_i = 8'd0; b_if.hi_thresh_i = 8'hFF;
    for (int c = 0; c <= 1005; c++) begin
      if (c == 1003) begin
        n_cmp++; if (b_if.done_o !== 1'b1) begin n_err++; $display("FAIL sat_done: got %b want 1", b_if.done_o); end
        n_cmp++; if (b_if.count_o[15:8] !== 8'd255) begin n_err++; $display("FAIL sat_ch1_count: got %0d want 255", b_if.count_o[15:8]); end
        n_cmp++; if (b_if.count_o[7:0] !== 8'd0) begin n_err++; $display("FAIL sat_ch0_count: got %0d want 0", b_if.count_o[7:0]); end
        n_cmp++; if (b_if.sat_o !== 4'b0010) begin n_err++; $display("FAIL sat_flags: got %b want 0010", b_if.sat_o); end
        n_cmp++; if (b_if.high_o !== 4'b0000) begin n_err++; $display("FAIL sat_high: got %b want 0000", b_if.high_o); end
      end
      b_if.start_i = (c == 0);
      b_if.mon_i = '0;
      b_if.mon_i[1] = c[0];
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_one_shot();
    test_thresholds();
    test_continuous_stop();
    test_reset_mid();
    test_ignored();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
